// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_mem_controller_pkg;

  // Access sequencer states: one 32-bit access is two 16-bit halves.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2,
    StDone = 2'd3
  } sram_state_e;

  localparam int unsigned SramDataLen = 16;
  localparam int unsigned SramAddrLen = 18;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  // Select the 16-bit half of a word carried by the given SRAM half-access.
  function automatic logic [SramDataLen-1:0] half_sel(input logic [31:0] word,
                                                      input logic        hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit asynchronous SRAM
// accesses with programmable wait states, stalling the pipeline until done.
import sram_mem_controller_pkg::*;

module sram_mem_controller #(
  parameter int unsigned WAIT_CYCLES     = 1,
  parameter int unsigned ADDR_BASE       = 1024,
  parameter int unsigned SRAM_ADDR_WIDTH = SramAddrLen
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [31:0]                address,
  input  logic [31:0]                write_data,
  output logic [31:0]                read_data,
  output logic                       ready,
  output logic                       freeze,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_we_n,
  output logic [SramDataLen-1:0]     sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [SramDataLen-1:0]     sram_dq_in
);

  localparam logic [2:0]  WaitLast  = 3'(WAIT_CYCLES);
  localparam int unsigned WordWidth = SRAM_ADDR_WIDTH - 1;

  sram_state_e          state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 op_write_q;
  logic [WordWidth-1:0] word_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;

  logic        req;
  logic        in_access;
  logic        half;
  logic        last_beat;
  logic [31:0] offset;
  logic        unused_bits;

  assign req       = mem_read | mem_write;
  // Byte offsets are word-aligned first so address[1:0] never borrows.
  assign offset    = {address[31:2], 2'b00} - 32'(ADDR_BASE);
  assign in_access = (state_q == StLow) || (state_q == StHigh);
  assign half      = (state_q == StHigh);
  assign last_beat = in_access && (cnt_q == WaitLast);

  assign unused_bits = ^{offset[31:SRAM_ADDR_WIDTH+1], offset[1:0], address[1:0]};

  // Next-state and wait-counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLow;
          cnt_d   = '0;
        end
      end
      StLow: begin
        if (last_beat) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StHigh: begin
        if (last_beat) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the request when it is accepted; live inputs are ignored afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_write_q <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
    end else if ((state_q == StIdle) && req) begin
      op_write_q <= mem_write;  // read+write together is a store
      word_q     <= offset[SRAM_ADDR_WIDTH:2];
      wdata_q    <= write_data;
    end
  end

  // Capture load data on the last cycle of each half.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (last_beat && !op_write_q) begin
      if (half) begin
        rdata_q[31:16] <= sram_dq_in;
      end else begin
        rdata_q[15:0] <= sram_dq_in;
      end
    end
  end

  // SRAM pin drive and pipeline handshake.
  always_comb begin
    ready       = Disable;
    sram_we_n   = 1'b1;
    sram_dq_oe  = Disable;
    sram_dq_out = '0;
    sram_addr   = {word_q, half};
    if (state_q == StIdle) begin
      ready = ~req;
    end else if (state_q == StDone) begin
      ready = Enable;
    end
    if (in_access && op_write_q) begin
      sram_dq_oe  = Enable;
      sram_dq_out = half_sel(wdata_q, half);
      // WE_n rises one cycle early so address/data hold across its edge.
      sram_we_n   = (WAIT_CYCLES != 0) && last_beat;
    end
  end

  assign freeze    = req & ~ready;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench: one controller with one wait state, one with none, each
// attached to its own behavioural SRAM.
module tb_sram_mem_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance with WAIT_CYCLES=1 (suffix 1) and WAIT_CYCLES=0 (suffix 0).
  logic        rd1, wr1, rd0, wr0;
  logic [31:0] a1, wd1, a0, wd0;
  logic [31:0] rdata1, rdata0;
  logic        ready1, freeze1, we1_n, oe1;
  logic        ready0, freeze0, we0_n, oe0;
  logic [17:0] sa1, sa0;
  logic [15:0] dqo1, dqi1, dqo0, dqi0;

  logic [15:0] mem1 [0:63];
  logic [15:0] mem0 [0:63];

  int checks = 0;
  int errors = 0;

  sram_mem_controller #(.WAIT_CYCLES(1), .ADDR_BASE(1024), .SRAM_ADDR_WIDTH(18)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .address(a1),
    .write_data(wd1), .read_data(rdata1), .ready(ready1), .freeze(freeze1),
    .sram_addr(sa1), .sram_we_n(we1_n), .sram_dq_out(dqo1), .sram_dq_oe(oe1),
    .sram_dq_in(dqi1)
  );

  sram_mem_controller #(.WAIT_CYCLES(0), .ADDR_BASE(1024), .SRAM_ADDR_WIDTH(18)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .address(a0),
    .write_data(wd0), .read_data(rdata0), .ready(ready0), .freeze(freeze0),
    .sram_addr(sa0), .sram_we_n(we0_n), .sram_dq_out(dqo0), .sram_dq_oe(oe0),
    .sram_dq_in(dqi0)
  );

  // Behavioural SRAMs: write while WE_n is low, read combinationally.
  always @(posedge clk) begin
    if (!we1_n) mem1[sa1[5:0]] <= dqo1;
    if (!we0_n) mem0[sa0[5:0]] <= dqo0;
  end
  assign dqi1 = mem1[sa1[5:0]];
  assign dqi0 = mem0[sa0[5:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input bit use0);
    if (use0) begin rd0 = 1'b0; wr0 = 1'b0; end
    else      begin rd1 = 1'b0; wr1 = 1'b0; end
  endtask

  // Drive one request and observe it until ready; returns at the DONE cycle
  // with the request still applied.
  task automatic access(input bit use0, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output int frz, output int we_lows,
                        output int oe_cnt, output logic [17:0] addr_lo,
                        output logic [17:0] addr_hi, output bit skipped);
    int hi_cycle;
    hi_cycle = use0 ? 2 : 3;
    if (use0) begin rd0 = rd; wr0 = wr; a0 = a; wd0 = wd; end
    else      begin rd1 = rd; wr1 = wr; a1 = a; wd1 = wd; end
    #1;
    skipped = 1'b0;
    // Still in DONE of the previous access: the request starts in the next cycle.
    if (use0 ? ready0 : ready1) begin
      skipped = 1'b1;
      step();
    end
    lat = 0; frz = 0; we_lows = 0; oe_cnt = 0; addr_lo = '1; addr_hi = '1;
    while (!(use0 ? ready0 : ready1) && lat < 40) begin
      if (use0 ? freeze0 : freeze1) frz++;
      if (!(use0 ? we0_n : we1_n)) we_lows++;
      if (use0 ? oe0 : oe1) oe_cnt++;
      if (lat == 1) addr_lo = use0 ? sa0 : sa1;
      if (lat == hi_cycle) addr_hi = use0 ? sa0 : sa1;
      step();
      lat++;
    end
  endtask

  int lat, frz, wel, oec, bad;
  logic [17:0] alo, ahi;
  bit skp;

  initial begin
    rst = 1'b1;
    rd1 = 0; wr1 = 0; a1 = 0; wd1 = 0;
    rd0 = 0; wr0 = 0; a0 = 0; wd0 = 0;
    step(); step();
    rst = 1'b0;
    #1;

    // Reset state
    check_eq("rst_ready", 32'(ready1), 32'd1);
    check_eq("rst_freeze", 32'(freeze1), 32'd0);
    check_eq("rst_we_n", 32'(we1_n), 32'd1);
    check_eq("rst_oe", 32'(oe1), 32'd0);
    check_eq("rst_rdata", rdata1, 32'd0);
    check_eq("rst_addr", 32'(sa1), 32'd0);
    check_eq("rst_dq_out", 32'(dqo1), 32'd0);
    step();

    // 1: store 0xDEADBEEF to 1028
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lat, frz, wel, oec, alo, ahi, skp);
    check_eq("t1_latency", 32'(lat), 32'd5);
    check_eq("t1_freeze_cycles", 32'(frz), 32'd5);
    check_eq("t1_we_low_cycles", 32'(wel), 32'd2);
    check_eq("t1_oe_cycles", 32'(oec), 32'd4);
    check_eq("t1_addr_lo", 32'(alo), 32'd2);
    check_eq("t1_addr_hi", 32'(ahi), 32'd3);
    check_eq("t1_mem2", 32'(mem1[2]), 32'h0000BEEF);
    check_eq("t1_mem3", 32'(mem1[3]), 32'h0000DEAD);
    check_eq("t1_rdata_kept", rdata1, 32'd0);
    idle(1'b0);
    step(); step();

    // 2: load from 1028
    access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, lat, frz, wel, oec, alo, ahi, skp);
    check_eq("t2_latency", 32'(lat), 32'd5);
    check_eq("t2_we_low_cycles", 32'(wel), 32'd0);
    check_eq("t2_oe_cycles", 32'(oec), 32'd0);
    check_eq("t2_addr_hi", 32'(ahi), 32'd3);
    check_eq("t2_rdata", rdata1, 32'hDEADBEEF);
    idle(1'b0);
    step();

    // 3: store to 1024 then an immediate load from 1024
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h11112222, lat, frz, wel, oec, alo, ahi, skp);
    check_eq("t3_store_latency", 32'(lat), 32'd5);
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, lat, frz, wel, oec, alo, ahi, skp);
    check_eq("t3_back_to_back", 32'(skp), 32'd1);
    check_eq("t3_load_latency", 32'(lat), 32'd5);
    check_eq("t3_addr_lo", 32'(alo), 32'd0);
    check_eq("t3_addr_hi", 32'(ahi), 32'd1);
    check_eq("t3_rdata", rdata1, 32'h11112222);
    idle(1'b0);
    step();
    check_eq("t3_idle_ready", 32'(ready1), 32'd1);
    check_eq("t3_idle_freeze", 32'(freeze1), 32'd0);

    // 4: reset during HIGH of a store
    rd1 = 1'b0; wr1 = 1'b1; a1 = 32'd1036; wd1 = 32'hAAAA5555;
    step(); step(); step();  // now in cycle 3, first HIGH cycle
    check_eq("t4_in_high_addr", 32'(sa1), 32'd7);
    rst = 1'b1;
    idle(1'b0);
    step();
    rst = 1'b0;
    #1;
    check_eq("t4_ready", 32'(ready1), 32'd1);
    check_eq("t4_freeze", 32'(freeze1), 32'd0);
    check_eq("t4_we_n", 32'(we1_n), 32'd1);
    check_eq("t4_oe", 32'(oe1), 32'd0);
    check_eq("t4_rdata", rdata1, 32'd0);
    step();

    // 5: read and write together is a store
    access(1'b0, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, lat, frz, wel, oec, alo, ahi, skp);
    check_eq("t5_latency", 32'(lat), 32'd5);
    check_eq("t5_we_low_cycles", 32'(wel), 32'd2);
    check_eq("t5_mem4", 32'(mem1[4]), 32'h0000F00D);
    check_eq("t5_mem5", 32'(mem1[5]), 32'h0000CAFE);
    check_eq("t5_rdata_kept", rdata1, 32'd0);
    idle(1'b0);
    step();

    // Misaligned load: address[1:0] ignored
    access(1'b0, 1'b1, 1'b0, 32'd1031, 32'h0, lat, frz, wel, oec, alo, ahi, skp);
    check_eq("misaligned_rdata", rdata1, 32'hDEADBEEF);
    idle(1'b0);
    step();

    // 6: zero wait states
    access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h12345678, lat, frz, wel, oec, alo, ahi, skp);
    check_eq("t6_store_latency", 32'(lat), 32'd3);
    check_eq("t6_we_low_cycles", 32'(wel), 32'd2);
    check_eq("t6_oe_cycles", 32'(oec), 32'd2);
    idle(1'b1);
    step();
    access(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, lat, frz, wel, oec, alo, ahi, skp);
    check_eq("t6_load_latency", 32'(lat), 32'd3);
    check_eq("t6_freeze_cycles", 32'(frz), 32'd3);
    check_eq("t6_addr_lo", 32'(alo), 32'd2);
    check_eq("t6_addr_hi", 32'(ahi), 32'd3);
    check_eq("t6_we_low_cycles_load", 32'(wel), 32'd0);
    check_eq("t6_rdata", rdata0, 32'h12345678);
    idle(1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!ready0 || !we0_n || freeze0 || oe0) bad++;
    end
    check_eq("t6_idle_bus", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
